insn_encoder_loader: RTL and testbench
======================================

// Module: insn_encoder_loader
// PURPOSE
//  Encoding end of the 8-bit instruction format: packs instruction fields into
//  {opcode[3:0], low[3:0]} bytes and writes them sequentially into instruction memory.
//  Sits between the debug/program-load path and instruction memory. Holds the CPU
//  (cpu_hold) for the whole load session; a 4-entry FIFO decouples field input from
//  memory back-pressure.
// PARAMETERS
//  ADDR_W      8   instruction memory address width (2^ADDR_W bytes)
//  FIFO_DEPTH  4   encoded-byte buffer depth; power of 2, >=2
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  rst          in   1       synchronous, active-high reset
//  start        in   1       begin load session (sampled only in IDLE)
//  base_addr    in   ADDR_W  first write address, latched on accepted start
//  in_valid     in   1       field set valid
//  in_ready     out  1       block accepts field set this cycle
//  in_opcode    in   4       opcode -> byte[7:4]
//  in_util      in   1       utility bit -> byte[3] (register form)
//  in_reg       in   3       register -> byte[2:0] (register form)
//  in_is_imm    in   1       1: low nibble = in_imm; 0: low nibble = {in_util,in_reg}
//  in_imm       in   4       4-bit immediate
//  in_last      in   1       marks final instruction of session
//  mem_we       out  1       write request, held until mem_ready
//  mem_ready    in   1       memory accepts write this cycle
//  mem_addr     out  ADDR_W  write address
//  mem_wdata    out  8       encoded instruction byte
//  cpu_hold     out  1       CPU stall while session active
//  done         out  1       one-cycle pulse: session complete
//  wrap_err     out  1       sticky: address wrapped past 2^ADDR_W-1 this session
//  words_cnt    out  ADDR_W+1 bytes written this session
// BEHAVIOUR
//  Reset: state=IDLE, FIFO empty; in_ready, mem_we, cpu_hold, done, wrap_err = 0;
//   mem_addr, mem_wdata, words_cnt = 0. Reset mid-session aborts it; partial writes remain.
//  Encoding: fixed-immediate opcodes (op[3]&op[2]&(op[1]|op[0]), i.e. 1101/1110/1111):
//   in_is_imm ignored, byte={op,in_util,in_reg}. Other opcodes: byte={op,in_imm} if
//   in_is_imm else {op,in_util,in_reg}.
//  FSM IDLE -> LOAD on start: latch base_addr into mem_addr; clear words_cnt and wrap_err;
//   cpu_hold=1 from the next cycle. start outside IDLE is ignored.
//  LOAD: in_ready = !fifo_full && !last_seen (registered full; no push-on-pop bypass).
//   Accept = in_valid&in_ready, pushes encoded byte. Accept with in_last sets last_seen,
//   -> DRAIN.
//  DRAIN: in_ready=0; writes continue. FIFO empty and no write pending -> DONE.
//  DONE: done=1 for exactly one cycle, cpu_hold=0, -> IDLE.
//  Write side (LOAD/DRAIN): mem_we=1 whenever FIFO non-empty; mem_wdata=FIFO head,
//   mem_addr stable while mem_we&!mem_ready. On mem_we&mem_ready: pop, mem_addr+1,
//   words_cnt+1.
//  Latency: byte accepted at cycle N is presented on mem_wdata/mem_we no earlier than N+1.
//  Simultaneous push and pop on a non-full FIFO: both occur, occupancy unchanged.
//  Wrap: write completing at address 2^ADDR_W-1 wraps mem_addr to 0 and sets wrap_err
//   (held until next accepted start).
//  Session ends only on in_last; a start pulse with no in_last keeps LOAD indefinitely.
// TESTING
//  1 base=0x10; in order (op=2,reg form u=1,r=5), (op=4,imm,imm=9), (op=1,reg form,last),
//    mem_ready=1 -> writes 0x2D@0x10, 0x49@0x11, 0x1?@0x12; done pulse; words_cnt=3;
//    cpu_hold falls with done.
//  2 op=0xE, in_is_imm=1, imm=0xF, u=0, r=3 -> mem_wdata=0xE3 (immediate ignored).
//  3 mem_ready=0, 6 back-to-back inputs -> in_ready drops after 4 accepts; mem_addr/wdata
//    held stable; release mem_ready -> all 6 written in order, no loss/dup.
//  4 ADDR_W=8, base=0xFE, 3 instrs -> addrs 0xFE, 0xFF, 0x00; wrap_err=1 until next start.
//  5 rst asserted mid-DRAIN with 2 bytes queued -> next cycle all outputs at reset values,
//    no further mem_we; start asserted while in LOAD -> ignored, mem_addr unchanged.

Source files
------------

// File: rtl/insn_encoder_loader.sv
// Instruction encoder/loader: packs instruction fields into {opcode, low nibble}
// bytes, buffers them in a small FIFO and writes them sequentially into
// instruction memory while holding the CPU for the duration of the load session.
module insn_encoder_loader #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [3:0]        i_in_opcode,
  input  logic              i_in_util,
  input  logic [2:0]        i_in_reg,
  input  logic              i_in_is_imm,
  input  logic [3:0]        i_in_imm,
  input  logic              i_in_last,
  output logic              o_mem_we,
  input  logic              i_mem_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_wrap_err,
  output logic [ADDR_W:0]   o_words_cnt
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned WCNT_W = ADDR_W + 1;

  // DRAIN doubles as the "last instruction seen" flag: an accept with
  // i_in_last always moves LOAD to DRAIN, where no further input is taken.
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [7:0]        r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              r_in_ready;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic              r_cpu_hold;
  logic              r_done;
  logic              r_wrap_err;
  logic [ADDR_W:0]   r_words_cnt;

  logic              w_fixed_imm;
  logic [7:0]        w_enc;
  logic              w_push;
  logic              w_pop;
  logic              w_start_acc;
  logic [CNT_W-1:0]  w_cnt_after_pop;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [PTR_W-1:0]  w_rd_ptr_nxt;
  logic [7:0]        w_head_nxt;

  // Opcodes 1101/1110/1111 always use the register-form low nibble.
  assign w_fixed_imm = i_in_opcode[3] & i_in_opcode[2] & (i_in_opcode[1] | i_in_opcode[0]);
  assign w_enc       = (i_in_is_imm && !w_fixed_imm) ? {i_in_opcode, i_in_imm}
                                                     : {i_in_opcode, i_in_util, i_in_reg};

  assign w_push      = i_in_valid & r_in_ready;
  assign w_pop       = r_mem_we & i_mem_ready;
  assign w_start_acc = (r_state == S_IDLE) & i_start;

  assign w_cnt_after_pop = r_count - CNT_W'(w_pop);
  assign w_count_nxt     = w_cnt_after_pop + CNT_W'(w_push);
  assign w_rd_ptr_nxt    = r_rd_ptr + PTR_W'(w_pop);
  // When the FIFO is emptied by this pop, the byte pushed now becomes the head.
  assign w_head_nxt      = (w_cnt_after_pop == '0) ? w_enc : r_fifo[w_rd_ptr_nxt];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic for the load session.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_LOAD;
      S_LOAD:  if (w_push && i_in_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_count == '0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FIFO storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_enc;
  end

  // FIFO pointers, write-side outputs and session status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_hold  <= 1'b0;
      r_done      <= 1'b0;
      r_wrap_err  <= 1'b0;
      r_words_cnt <= '0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + PTR_W'(w_push);
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_count_nxt;
      r_mem_we   <= (w_count_nxt != '0);
      if (w_count_nxt != '0) r_mem_wdata <= w_head_nxt;
      r_in_ready <= (w_state_nxt == S_LOAD) && (w_count_nxt < CNT_W'(FIFO_DEPTH));
      r_cpu_hold <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_DRAIN);
      r_done     <= (w_state_nxt == S_DONE);
      if (w_start_acc) begin
        r_mem_addr  <= i_base_addr;
        r_words_cnt <= '0;
        r_wrap_err  <= 1'b0;
      end else if (w_pop) begin
        r_mem_addr  <= r_mem_addr + ADDR_W'(1);
        r_words_cnt <= r_words_cnt + WCNT_W'(1);
        if (r_mem_addr == '1) r_wrap_err <= 1'b1;
      end
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_cpu_hold  = r_cpu_hold;
  assign o_done      = r_done;
  assign o_wrap_err  = r_wrap_err;
  assign o_words_cnt = r_words_cnt;

endmodule

// File: tb/tb_insn_encoder_loader.sv
// Testbench for insn_encoder_loader: random load sessions checked against a
// reference encoder and an address/sequence model of the memory write stream.
module tb_insn_encoder_loader;

  typedef struct packed {
    logic [3:0] op;
    logic       u;
    logic [2:0] r;
    logic       is_imm;
    logic [3:0] imm;
  } item_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start;
  logic [7:0] i_base_addr;
  logic       i_in_valid;
  logic       o_in_ready;
  logic [3:0] i_in_opcode;
  logic       i_in_util;
  logic [2:0] i_in_reg;
  logic       i_in_is_imm;
  logic [3:0] i_in_imm;
  logic       i_in_last;
  logic       o_mem_we;
  logic       i_mem_ready;
  logic [7:0] o_mem_addr;
  logic [7:0] o_mem_wdata;
  logic       o_cpu_hold;
  logic       o_done;
  logic       o_wrap_err;
  logic [8:0] o_words_cnt;

  int errors = 0;
  int checks = 0;

  item_t       items[$];
  logic [15:0] obs_q[$];

  // session results
  bit         s_done_seen, s_hold_ok, s_hold_at_done, s_pulse_ok, s_wrap, s_rdy_at_hold;
  int         s_acc_at_hold;
  logic [8:0] s_words;
  logic [7:0] s_addr_at_done, s_addr_at_hold;

  // stall monitor state
  bit         stall_prev = 0;
  logic [7:0] addr_prev, data_prev;
  int         stall_viol = 0;

  insn_encoder_loader #(.ADDR_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_opcode(i_in_opcode),
    .i_in_util(i_in_util), .i_in_reg(i_in_reg), .i_in_is_imm(i_in_is_imm),
    .i_in_imm(i_in_imm), .i_in_last(i_in_last), .o_mem_we(o_mem_we),
    .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_cpu_hold(o_cpu_hold), .o_done(o_done), .o_wrap_err(o_wrap_err),
    .o_words_cnt(o_words_cnt)
  );

  always #5 clk = ~clk;

  // Records every completed memory write and flags any change while stalled.
  always @(posedge clk) begin
    if (!rst && o_mem_we && i_mem_ready) obs_q.push_back({o_mem_addr, o_mem_wdata});
    if (stall_prev && !rst && (!o_mem_we || o_mem_addr !== addr_prev || o_mem_wdata !== data_prev))
      stall_viol++;
    stall_prev = !rst && o_mem_we && !i_mem_ready;
    addr_prev  = o_mem_addr;
    data_prev  = o_mem_wdata;
  end

  // Reference encoding: opcodes 13..15 carry a register-form low nibble regardless of is_imm.
  function automatic logic [7:0] ref_encode(input item_t it);
    if (it.op >= 4'd13 || !it.is_imm) return {it.op, it.u, it.r};
    return {it.op, it.imm};
  endfunction

  task automatic gen_items(input int n);
    item_t it;
    items.delete();
    for (int k = 0; k < n; k++) begin
      it = item_t'($urandom);
      items.push_back(it);
    end
  endtask

  task automatic drive_item(input item_t it, input bit last);
    i_in_opcode = it.op;  i_in_util = it.u;  i_in_reg = it.r;
    i_in_is_imm = it.is_imm;  i_in_imm = it.imm;  i_in_last = last;
    i_in_valid  = 1'b1;
  endtask

  // Runs one session over `items`; called and returns at a negedge.
  task automatic drive_session(input logic [7:0] base, input int ready_pct,
                               input int valid_pct, input int hold_cyc);
    int idx = 0;
    int cyc = 0;
    bit acc;
    obs_q.delete();
    s_done_seen = 0; s_hold_ok = 1; s_acc_at_hold = -1; s_rdy_at_hold = 1;
    i_start = 1'b1; i_base_addr = base; i_in_valid = 1'b0; i_mem_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    i_start = 1'b0; i_base_addr = 8'($urandom);
    while (!s_done_seen && cyc < 3000) begin
      if (cyc == hold_cyc) begin
        s_acc_at_hold = idx; s_rdy_at_hold = o_in_ready; s_addr_at_hold = o_mem_addr;
      end
      i_mem_ready = (cyc < hold_cyc) ? 1'b0 : ($urandom_range(99) < ready_pct);
      if (idx < items.size() && (cyc < hold_cyc || $urandom_range(99) < valid_pct))
        drive_item(items[idx], idx == items.size() - 1);
      else begin
        drive_item(item_t'($urandom), 1'($urandom));
        i_in_valid = 1'b0;
      end
      acc = i_in_valid && o_in_ready;
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
      cyc++;
      if (o_done) begin
        s_done_seen = 1; s_words = o_words_cnt; s_wrap = o_wrap_err;
        s_hold_at_done = o_cpu_hold; s_addr_at_done = o_mem_addr;
      end else if (!o_cpu_hold) s_hold_ok = 0;
    end
    i_in_valid = 1'b0; i_mem_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    s_pulse_ok = !o_done && !o_cpu_hold;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 0; i_base_addr = 0; i_in_valid = 0; i_in_opcode = 0;
    i_in_util = 0; i_in_reg = 0; i_in_is_imm = 0; i_in_imm = 0; i_in_last = 0; i_mem_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({o_in_ready, o_mem_we, o_cpu_hold, o_done, o_wrap_err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got=%b exp=00000",
                         {o_in_ready, o_mem_we, o_cpu_hold, o_done, o_wrap_err});
    end
    checks++;
    if ({o_mem_addr, o_mem_wdata, o_words_cnt} !== 25'd0) begin
      errors++; $display("FAIL reset_data got addr=%h wdata=%h words=%0d exp=0",
                         o_mem_addr, o_mem_wdata, o_words_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    item_t it;
    logic [15:0] exp;
    items.delete();
    it = '{op: 4'd2, u: 1'b1, r: 3'd5, is_imm: 1'b0, imm: 4'($urandom)}; items.push_back(it);
    it = '{op: 4'd4, u: 1'($urandom), r: 3'($urandom), is_imm: 1'b1, imm: 4'd9}; items.push_back(it);
    it = '{op: 4'd1, u: 1'($urandom), r: 3'($urandom), is_imm: 1'b0, imm: 4'($urandom)}; items.push_back(it);
    drive_session(8'h10, 100, 100, -1);
    checks++;
    if (!s_done_seen) begin errors++; $display("FAIL basic_timeout no done pulse"); end
    for (int k = 0; k < 3; k++) begin
      exp = {8'h10 + 8'(k), ref_encode(items[k])};
      checks++;
      if (k >= obs_q.size() || obs_q[k] !== exp) begin
        errors++; $display("FAIL basic_write%0d got=%h exp=%h", k,
                           (k < obs_q.size()) ? obs_q[k] : 16'hxxxx, exp);
      end
    end
    checks++;
    if (obs_q.size() >= 2 && obs_q[0][7:0] !== 8'h2D) begin
      errors++; $display("FAIL basic_byte0 got=%h exp=2d", obs_q[0][7:0]);
    end
    checks++;
    if (s_words !== 9'd3) begin errors++; $display("FAIL basic_words got=%0d exp=3", s_words); end
    checks++;
    if (s_hold_at_done !== 1'b0 || !s_hold_ok || !s_pulse_ok) begin
      errors++; $display("FAIL basic_hold_done hold_at_done=%b hold_ok=%b pulse_ok=%b exp=0,1,1",
                         s_hold_at_done, s_hold_ok, s_pulse_ok);
    end
  endtask

  task automatic test_fixed_imm();
    item_t it;
    logic [15:0] exp;
    items.delete();
    it = '{op: 4'hE, u: 1'b0, r: 3'd3, is_imm: 1'b1, imm: 4'hF}; items.push_back(it);
    for (int k = 0; k < 5; k++) begin
      it = item_t'($urandom);
      it.op = 4'(13 + $urandom_range(2));
      it.is_imm = 1'b1;
      items.push_back(it);
    end
    drive_session(8'h60, 80, 80, -1);
    checks++;
    if (obs_q.size() < 1 || obs_q[0][7:0] !== 8'hE3) begin
      errors++; $display("FAIL fixed_imm_E got=%h exp=e3",
                         (obs_q.size() > 0) ? obs_q[0][7:0] : 8'hxx);
    end
    for (int k = 0; k < items.size(); k++) begin
      exp = {8'h60 + 8'(k), ref_encode(items[k])};
      checks++;
      if (k >= obs_q.size() || obs_q[k] !== exp) begin
        errors++; $display("FAIL fixed_write%0d got=%h exp=%h", k,
                           (k < obs_q.size()) ? obs_q[k] : 16'hxxxx, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    gen_items(6);
    stall_viol = 0;
    drive_session(8'h80, 100, 100, 12);
    checks++;
    if (s_acc_at_hold != 4 || s_rdy_at_hold !== 1'b0) begin
      errors++; $display("FAIL bp_fill accepts=%0d in_ready=%b exp=4,0", s_acc_at_hold, s_rdy_at_hold);
    end
    checks++;
    if (s_addr_at_hold !== 8'h80 || stall_viol != 0) begin
      errors++; $display("FAIL bp_stable addr=%h viol=%0d exp=80,0", s_addr_at_hold, stall_viol);
    end
    checks++;
    if (obs_q.size() != 6 || s_words !== 9'd6) begin
      errors++; $display("FAIL bp_count writes=%0d words=%0d exp=6", obs_q.size(), s_words);
    end
    for (int k = 0; k < 6; k++) begin
      exp = {8'h80 + 8'(k), ref_encode(items[k])};
      checks++;
      if (k >= obs_q.size() || obs_q[k] !== exp) begin
        errors++; $display("FAIL bp_write%0d got=%h exp=%h", k,
                           (k < obs_q.size()) ? obs_q[k] : 16'hxxxx, exp);
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp;
    gen_items(3);
    drive_session(8'hFE, 70, 80, -1);
    for (int k = 0; k < 3; k++) begin
      exp = {8'hFE + 8'(k), ref_encode(items[k])};
      checks++;
      if (k >= obs_q.size() || obs_q[k] !== exp) begin
        errors++; $display("FAIL wrap_write%0d got=%h exp=%h", k,
                           (k < obs_q.size()) ? obs_q[k] : 16'hxxxx, exp);
      end
    end
    checks++;
    if (s_wrap !== 1'b1) begin errors++; $display("FAIL wrap_err_set got=%b exp=1", s_wrap); end
    repeat (4) @(negedge clk);
    checks++;
    if (o_wrap_err !== 1'b1) begin errors++; $display("FAIL wrap_err_sticky got=%b exp=1", o_wrap_err); end
    gen_items(2);
    drive_session(8'h20, 100, 100, -1);
    checks++;
    if (s_wrap !== 1'b0 || s_addr_at_done !== 8'h22) begin
      errors++; $display("FAIL wrap_err_clear wrap=%b addr=%h exp=0,22", s_wrap, s_addr_at_done);
    end
  endtask

  task automatic test_reset_abort();
    int bad_we = 0;
    gen_items(2);
    i_start = 1'b1; i_base_addr = 8'h30; i_mem_ready = 1'b0; i_in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    i_start = 1'b0;
    drive_item(items[0], 1'b0);
    @(posedge clk); @(negedge clk);
    drive_item(items[1], 1'b1);
    @(posedge clk); @(negedge clk);
    i_in_valid = 1'b0;
    checks++;
    if (o_mem_we !== 1'b1 || o_cpu_hold !== 1'b1) begin
      errors++; $display("FAIL abort_pre we=%b hold=%b exp=1,1", o_mem_we, o_cpu_hold);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({o_in_ready, o_mem_we, o_cpu_hold, o_done, o_wrap_err, o_mem_addr, o_mem_wdata, o_words_cnt} !== 30'd0) begin
      errors++; $display("FAIL abort_reset got rdy=%b we=%b hold=%b addr=%h wdata=%h words=%0d exp=0",
                         o_in_ready, o_mem_we, o_cpu_hold, o_mem_addr, o_mem_wdata, o_words_cnt);
    end
    rst = 1'b0; i_mem_ready = 1'b1; obs_q.delete();
    repeat (10) begin
      @(negedge clk);
      if (o_mem_we !== 1'b0) bad_we++;
    end
    checks++;
    if (bad_we != 0 || obs_q.size() != 0) begin
      errors++; $display("FAIL abort_no_write we_cycles=%0d writes=%0d exp=0,0", bad_we, obs_q.size());
    end
  endtask

  task automatic test_start_ignored();
    int cyc = 0;
    gen_items(1);
    obs_q.delete();
    i_start = 1'b1; i_base_addr = 8'h40; i_mem_ready = 1'b1; i_in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    repeat (5) begin
      i_base_addr = 8'h80 + 8'($urandom_range(15));
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (o_mem_addr !== 8'h40 || o_cpu_hold !== 1'b1 || o_words_cnt !== 9'd0) begin
      errors++; $display("FAIL start_ignored addr=%h hold=%b words=%0d exp=40,1,0",
                         o_mem_addr, o_cpu_hold, o_words_cnt);
    end
    i_start = 1'b0;
    drive_item(items[0], 1'b1);
    @(posedge clk); @(negedge clk);
    i_in_valid = 1'b0;
    while (!o_done && cyc < 50) begin @(posedge clk); @(negedge clk); cyc++; end
    checks++;
    if (!o_done || obs_q.size() != 1 || obs_q[0] !== {8'h40, ref_encode(items[0])}) begin
      errors++; $display("FAIL start_ignored_write done=%b writes=%0d got=%h exp=%h", o_done,
                         obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 16'hxxxx,
                         {8'h40, ref_encode(items[0])});
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0]  base;
    logic [15:0] exp;
    int          n;
    bit          exp_wrap;
    for (int s = 0; s < 10; s++) begin
      n    = 1 + $urandom_range(9);
      base = (s < 3) ? 8'(250 + $urandom_range(5)) : 8'($urandom);
      gen_items(n);
      drive_session(base, 20 + $urandom_range(80), 20 + $urandom_range(80), -1);
      exp_wrap = (int'(base) + n >= 256);
      checks++;
      if (!s_done_seen || s_words !== 9'(n) || s_wrap !== exp_wrap ||
          s_addr_at_done !== base + 8'(n) || !s_hold_ok || !s_pulse_ok) begin
        errors++; $display("FAIL rand%0d_status done=%b words=%0d wrap=%b addr=%h exp words=%0d wrap=%b addr=%h",
                           s, s_done_seen, s_words, s_wrap, s_addr_at_done, n, exp_wrap, base + 8'(n));
      end
      for (int k = 0; k < n; k++) begin
        exp = {base + 8'(k), ref_encode(items[k])};
        checks++;
        if (k >= obs_q.size() || obs_q[k] !== exp) begin
          errors++; $display("FAIL rand%0d_write%0d got=%h exp=%h", s, k,
                             (k < obs_q.size()) ? obs_q[k] : 16'hxxxx, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fixed_imm();
    test_back_to_back();
    test_wrap();
    test_reset_abort();
    test_start_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
